// File: rtl/mod5_stream_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mod5_stream_pkg : shared types/constants for the mod-5 word stream path
// Revision: 1.0
// ----------------------------------------------------------------------------
package mod5_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  localparam int MOD           = 5;
  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width; a 1-bit word still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod5_piso.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mod5_piso : WIDTH-bit parallel-in / serial-out shift register, MSB first
// Revision: 1.0
// ----------------------------------------------------------------------------
module mod5_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             msb
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_data;
    end else if (shift_en) begin
      data_d = data_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb = data_q[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/mod5_word_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mod5_word_feeder : feeds words bit-serially into the mod-5 detector and
//                    returns the divisibility flag with the original word
// Revision: 1.0
// ----------------------------------------------------------------------------
module mod5_word_feeder
  import mod5_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             det_resetn,
  output logic             det_din,
  input  logic             det_dout,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_div5,
  input  logic             res_ready
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_d,     state_q;
  logic [CW-1:0]    cnt_d,       cnt_q;
  logic [WIDTH-1:0] res_data_d,  res_data_q;
  logic             res_div5_d,  res_div5_q;
  logic             in_ready_d,  in_ready_q;
  logic             res_valid_d, res_valid_q;

  logic             piso_load;
  logic             piso_shift;
  logic             piso_msb;

  mod5_piso #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk       (clk),
    .reset     (reset),
    .load      (piso_load),
    .load_data (in_data),
    .shift_en  (piso_shift),
    .msb       (piso_msb)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_div5_d = res_div5_q;
    piso_load  = 1'b0;
    piso_shift = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          piso_load  = 1'b1;
          res_data_d = in_data;
          cnt_d      = CW'(WIDTH - 1);
          state_d    = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        piso_shift = 1'b1;
        // Exit after the cycle that drives bit 0; the counter never wraps.
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_SAMPLE: begin
        res_div5_d = det_dout;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    res_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_div5_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_div5_q  <= res_div5_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Reset must reach the detector immediately, so this stays combinational.
  assign det_resetn = ~(reset | (state_q == ST_CLEAR));
  assign det_din    = (state_q == ST_SHIFT) ? piso_msb : 1'b0;

  assign in_ready   = in_ready_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_div5   = res_div5_q;

endmodule
`default_nettype wire

// File: tb/tb_mod5_word_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mod5_word_feeder : directed bench for WIDTH=8 and WIDTH=1 feeders, each
//                       driving a behavioural serial mod-5 detector
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mod5_word_feeder;

  logic       clk = 1'b0;
  logic       reset;

  logic       in_valid8, in_ready8, det_resetn8, det_din8, det_dout8;
  logic       res_valid8, res_div5_8, res_ready8;
  logic [7:0] in_data8, res_data8;

  logic       in_valid1, in_ready1, det_resetn1, det_din1, det_dout1;
  logic       res_valid1, res_div5_1, res_ready1;
  logic [0:0] in_data1, res_data1;

  logic [2:0] rem8, rem1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mod5_word_feeder #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid8),
    .in_data    (in_data8),
    .in_ready   (in_ready8),
    .det_resetn (det_resetn8),
    .det_din    (det_din8),
    .det_dout   (det_dout8),
    .res_valid  (res_valid8),
    .res_data   (res_data8),
    .res_div5   (res_div5_8),
    .res_ready  (res_ready8)
  );

  mod5_word_feeder #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid1),
    .in_data    (in_data1),
    .in_ready   (in_ready1),
    .det_resetn (det_resetn1),
    .det_din    (det_din1),
    .det_dout   (det_dout1),
    .res_valid  (res_valid1),
    .res_data   (res_data1),
    .res_div5   (res_div5_1),
    .res_ready  (res_ready1)
  );

  // Serial remainder detector: rem <- (2*rem + bit) mod 5, flag when rem == 0.
  always @(posedge clk) begin
    if (!det_resetn8) rem8 <= 3'd0;
    else              rem8 <= 3'((int'(rem8) * 2 + int'(det_din8)) % 5);
    if (!det_resetn1) rem1 <= 3'd0;
    else              rem1 <= 3'((int'(rem1) * 2 + int'(det_din1)) % 5);
  end
  assign det_dout8 = (rem8 == 3'd0);
  assign det_dout1 = (rem1 == 3'd0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in an IDLE cycle; returns in the cycle where in_ready is back at 1.
  task automatic run_word8(input logic [7:0] data, input logic exp_div5, input int hold);
    res_ready8 = (hold == 0);
    in_valid8  = 1'b1;
    in_data8   = data;
    check("w8_idle_in_ready", in_ready8, 1);
    tick();
    in_valid8 = 1'b0;
    in_data8  = ~data;
    check("w8_clear_resetn", det_resetn8, 0);
    check("w8_clear_din", det_din8, 0);
    check("w8_busy_in_ready", in_ready8, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("w8_din_k%0d", k), det_din8, data[7-k]);
      check("w8_shift_resetn", det_resetn8, 1);
    end
    tick();
    check("w8_sample_no_valid", res_valid8, 0);
    tick();
    check("w8_res_valid", res_valid8, 1);
    check("w8_res_div5", res_div5_8, exp_div5);
    check("w8_res_data", res_data8, data);
    check("w8_hold_in_ready", in_ready8, 0);
    if (hold > 0) begin
      in_valid8 = 1'b1;
      in_data8  = 8'hAA;
    end
    for (int i = 1; i <= hold; i++) begin
      tick();
      check("w8_bp_valid", res_valid8, 1);
      check("w8_bp_data", res_data8, data);
      check("w8_bp_div5", res_div5_8, exp_div5);
      check("w8_bp_in_ready", in_ready8, 0);
      if (i == hold) begin
        res_ready8 = 1'b1;
        in_valid8  = 1'b0;
      end
    end
    tick();
    check("w8_done_in_ready", in_ready8, 1);
    check("w8_done_valid", res_valid8, 0);
  endtask

  task automatic run_word1(input logic [0:0] data, input logic exp_div5);
    in_valid1  = 1'b1;
    in_data1   = data;
    res_ready1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check("w1_clear_resetn", det_resetn1, 0);
    check("w1_busy_in_ready", in_ready1, 0);
    tick();
    check("w1_din", det_din1, data);
    check("w1_shift_resetn", det_resetn1, 1);
    tick();
    check("w1_sample_no_valid", res_valid1, 0);
    tick();
    check("w1_res_valid", res_valid1, 1);
    check("w1_res_div5", res_div5_1, exp_div5);
    check("w1_res_data", res_data1, data);
    tick();
    check("w1_done_in_ready", in_ready1, 1);
  endtask

  initial begin
    int nvalid;
    int pulses;
    int vcyc [2];
    logic [7:0] vdata [2];
    logic vdiv [2];

    reset      = 1'b1;
    in_valid8  = 1'b0; in_data8 = 8'h00; res_ready8 = 1'b1;
    in_valid1  = 1'b0; in_data1 = 1'b0;  res_ready1 = 1'b1;
    tick();
    tick();
    check("rst_in_ready8", in_ready8, 1);
    check("rst_res_valid8", res_valid8, 0);
    check("rst_res_div5_8", res_div5_8, 0);
    check("rst_res_data8", res_data8, 0);
    check("rst_det_din8", det_din8, 0);
    check("rst_det_resetn8", det_resetn8, 0);
    check("rst_in_ready1", in_ready1, 1);
    check("rst_det_resetn1", det_resetn1, 0);
    reset = 1'b0;
    tick();
    check("idle_det_resetn8", det_resetn8, 1);
    check("idle_det_din8", det_din8, 0);

    run_word8(8'h0A, 1'b1, 0);
    run_word8(8'h07, 1'b0, 0);
    run_word8(8'h00, 1'b1, 0);
    run_word8(8'hFF, 1'b1, 0);
    run_word8(8'hFE, 1'b0, 0);
    run_word8(8'h0F, 1'b1, 5);

    // Back-to-back: 0x14 then 0x13 with in_valid held high.
    nvalid = 0;
    pulses = 0;
    vcyc[0] = -1; vcyc[1] = -1;
    vdata[0] = '0; vdata[1] = '0;
    vdiv[0] = 1'b0; vdiv[1] = 1'b0;
    res_ready8 = 1'b1;
    in_valid8  = 1'b1;
    in_data8   = 8'h14;
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (c == 1)  in_data8  = 8'h13;
      if (c == 13) in_valid8 = 1'b0;
      if (!det_resetn8) pulses++;
      if (res_valid8) begin
        if (nvalid < 2) begin
          vcyc[nvalid]  = c;
          vdata[nvalid] = res_data8;
          vdiv[nvalid]  = res_div5_8;
        end
        nvalid++;
      end
    end
    check("b2b_count", nvalid, 2);
    check("b2b_cycle0", vcyc[0], 11);
    check("b2b_cycle1", vcyc[1], 23);
    check("b2b_data0", vdata[0], 8'h14);
    check("b2b_div0", vdiv[0], 1);
    check("b2b_data1", vdata[1], 8'h13);
    check("b2b_div1", vdiv[1], 0);
    check("b2b_clear_pulses", pulses, 2);
    check("b2b_idle", in_ready8, 1);

    // Reset asserted in cycle 5 of a word.
    in_valid8 = 1'b1;
    in_data8  = 8'h0F;
    tick();
    in_valid8 = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check("rst_mid_resetn_now", det_resetn8, 0);
    tick();
    check("rst_mid_in_ready", in_ready8, 1);
    check("rst_mid_res_valid", res_valid8, 0);
    check("rst_mid_resetn", det_resetn8, 0);
    check("rst_mid_din", det_din8, 0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_mid_release_resetn", det_resetn8, 1);
    run_word8(8'h05, 1'b1, 0);

    // Reset while a result is pending discards it.
    res_ready8 = 1'b0;
    in_valid8  = 1'b1;
    in_data8   = 8'h0A;
    tick();
    in_valid8 = 1'b0;
    repeat (10) tick();
    check("rst_hold_valid_before", res_valid8, 1);
    reset = 1'b1;
    tick();
    check("rst_hold_valid", res_valid8, 0);
    check("rst_hold_data", res_data8, 0);
    check("rst_hold_div5", res_div5_8, 0);
    check("rst_hold_in_ready", in_ready8, 1);
    reset      = 1'b0;
    res_ready8 = 1'b1;
    tick();

    run_word1(1'b0, 1'b1);
    run_word1(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
